// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data memory: FSM states, legal lane masks and
// the wait-state counter sizing helper.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } memState_t;

    localparam logic [3:0] BeByte0 = 4'b0001;
    localparam logic [3:0] BeByte1 = 4'b0010;
    localparam logic [3:0] BeByte2 = 4'b0100;
    localparam logic [3:0] BeByte3 = 4'b1000;
    localparam logic [3:0] BeHalf0 = 4'b0011;
    localparam logic [3:0] BeHalf1 = 4'b1100;
    localparam logic [3:0] BeWord  = 4'b1111;

    // The counter is loaded with waitStates-1, so it never has to hold waitStates itself.
    function automatic int unsigned waitCountWidth(input int unsigned waitStates);
        return (waitStates <= 2) ? 1 : $clog2(waitStates);
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word-organised storage with per-lane write enables and a registered, clearable read port.
// The storage itself is not reset; only the read register is.
module mips_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IndexWidth = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [IndexWidth-1:0] index,
    input  logic [3:0]            writeEn,
    input  logic [31:0]           writeData,
    input  logic                  readEn,
    input  logic                  readClear,
    output logic [31:0]           readData
);

    logic [31:0] storage [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (writeEn[lane]) begin
                storage[index][8*lane +: 8] <= writeData[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            readData <= '0;
        end else if (readClear) begin
            readData <= '0;
        end else if (readEn) begin
            readData <= storage[index];
        end
    end

endmodule

// File: rtl/mips_data_memory.sv
// Handshaked data memory: accepts one read or write, optionally waits, then pulses ready for
// one cycle, rejecting misaligned, illegal-lane or out-of-range accesses with fault.
module mips_data_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] readData,
    output logic        ready,
    output logic        fault
);

    localparam int unsigned IndexWidth = $clog2(DEPTH_WORDS);
    localparam int unsigned CountWidth = waitCountWidth(WAIT_STATES);
    localparam logic [CountWidth-1:0] WaitLoad =
        (WAIT_STATES == 0) ? '0 : CountWidth'(WAIT_STATES - 1);

    memState_t             stateQ;
    logic [CountWidth-1:0] countQ;
    logic [IndexWidth-1:0] indexQ;
    logic [31:0]           writeDataQ;
    logic [3:0]            byteEnableQ;
    logic                  isWriteQ;
    logic                  faultQ;
    logic                  readyQ;
    logic                  faultOutQ;

    logic                  request;
    logic [31:0]           wordOffset;
    logic [IndexWidth-1:0] indexNow;
    logic                  rangeFault;
    logic                  laneLegal;
    logic                  faultNow;

    logic                  useLive;
    logic                  fire;
    logic                  opWrite;
    logic                  opFault;
    logic [IndexWidth-1:0] opIndex;
    logic [31:0]           opData;
    logic [3:0]            opByteEnable;

    assign request = memRead | memWrite;
    // Unsigned wrap sends addresses below the base far out of range.
    assign wordOffset = (address - BASE_ADDR) >> 2;
    assign indexNow   = wordOffset[IndexWidth-1:0];
    assign rangeFault = wordOffset >= 32'(DEPTH_WORDS);

    always_comb begin
        laneLegal = 1'b0;
        unique case (byteEnable)
            BeByte0, BeHalf0, BeWord: laneLegal = (address[1:0] == 2'd0);
            BeByte1:                  laneLegal = (address[1:0] == 2'd1);
            BeByte2, BeHalf1:         laneLegal = (address[1:0] == 2'd2);
            BeByte3:                  laneLegal = (address[1:0] == 2'd3);
            default:                  laneLegal = 1'b0;
        endcase
    end

    assign faultNow = (memRead & memWrite) | rangeFault |
                      (memRead & (address[1:0] != 2'd0)) |
                      (memWrite & ~laneLegal);

    // With no wait states the storage access happens on the acceptance edge itself, so the
    // live request drives the array; otherwise the latched copy does.
    assign useLive      = (stateQ == StIdle);
    assign fire         = useLive ? (request && (WAIT_STATES == 0))
                                  : ((stateQ == StWait) && (countQ == '0));
    assign opWrite      = useLive ? memWrite   : isWriteQ;
    assign opFault      = useLive ? faultNow   : faultQ;
    assign opIndex      = useLive ? indexNow   : indexQ;
    assign opData       = useLive ? writeData  : writeDataQ;
    assign opByteEnable = useLive ? byteEnable : byteEnableQ;

    mips_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) memArray (
        .clock    (clock),
        .resetN   (resetN),
        .index    (opIndex),
        .writeEn  (opByteEnable & {4{fire & opWrite & ~opFault}}),
        .writeData(opData),
        .readEn   (fire & ~opWrite & ~opFault),
        .readClear(fire & opFault),
        .readData (readData)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateQ      <= StIdle;
            countQ      <= '0;
            indexQ      <= '0;
            writeDataQ  <= '0;
            byteEnableQ <= '0;
            isWriteQ    <= 1'b0;
            faultQ      <= 1'b0;
            readyQ      <= 1'b0;
            faultOutQ   <= 1'b0;
        end else begin
            readyQ    <= 1'b0;
            faultOutQ <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (request) begin
                        indexQ      <= indexNow;
                        writeDataQ  <= writeData;
                        byteEnableQ <= byteEnable;
                        isWriteQ    <= memWrite;
                        faultQ      <= faultNow;
                        if (WAIT_STATES == 0) begin
                            stateQ    <= StResp;
                            readyQ    <= 1'b1;
                            faultOutQ <= faultNow;
                        end else begin
                            stateQ <= StWait;
                            countQ <= WaitLoad;
                        end
                    end
                end
                StWait: begin
                    if (countQ == '0) begin
                        stateQ    <= StResp;
                        readyQ    <= 1'b1;
                        faultOutQ <= faultQ;
                    end else begin
                        countQ <= countQ - 1'b1;
                    end
                end
                StResp: stateQ <= StIdle;
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign ready = readyQ;
    assign fault = faultOutQ;

endmodule

// File: tb/tb_mips_data_memory.sv
// Bench for mips_data_memory: a zero-wait instance driven by a vector table and random traffic
// against a word-array model, and a three-wait instance for latency and reset corner cases.
module tb_mips_data_memory;

    localparam int unsigned Depth = 1024;
    localparam logic [31:0] Base  = 32'h10010000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetN0, rd0, wr0, ready0, fault0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;
    logic        resetN3, rd3, wr3, ready3, fault3;
    logic [31:0] addr3, wdata3, rdata3;
    logic [3:0]  be3;

    mips_data_memory #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_STATES(0)) dut0 (
        .clock(clock), .resetN(resetN0), .memRead(rd0), .memWrite(wr0), .address(addr0),
        .writeData(wdata0), .byteEnable(be0), .readData(rdata0), .ready(ready0), .fault(fault0)
    );

    mips_data_memory #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .WAIT_STATES(3)) dut3 (
        .clock(clock), .resetN(resetN3), .memRead(rd3), .memWrite(wr3), .address(addr3),
        .writeData(wdata3), .byteEnable(be3), .readData(rdata3), .ready(ready3), .fault(fault3)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem [Depth];
    logic [31:0] refRead;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] expData;
        logic        expFault;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: the memory is a plain word array; an access is legal or not by the stated rules.
    function automatic logic refApply(input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] data, input logic [3:0] be);
        logic [31:0] off;
        int unsigned idx;
        int          lowLane;
        logic        ok;
        off     = addr - Base;
        idx     = off / 4;
        lowLane = -1;
        for (int k = 3; k >= 0; k--) if (be[k]) lowLane = k;
        if (rd && wr)                ok = 1'b0;
        else if (idx >= Depth)       ok = 1'b0;
        else if (rd)                 ok = (addr % 4) == 0;
        else                         ok = (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                                      4'b0011, 4'b1100, 4'b1111}) &&
                                          (lowLane == int'(addr % 4));
        if (!ok) refRead = 32'h0;
        else if (rd) refRead = refMem[idx];
        else for (int k = 0; k < 4; k++) if (be[k]) refMem[idx][8*k +: 8] = data[8*k +: 8];
        return !ok;
    endfunction

    // One complete access on the zero-wait instance; leaves it idle afterwards.
    task automatic access0(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input string name,
                           output logic [31:0] gotData, output logic gotFault);
        int n;
        n = 0;
        @(negedge clock);
        rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data; be0 = be;
        do begin
            @(posedge clock); #1; n++;
        end while (!ready0 && n < 20);
        gotData  = rdata0;
        gotFault = fault0;
        rd0 = 1'b0; wr0 = 1'b0;
        check({name, " latency"}, 32'(n), 32'd1);
        @(posedge clock); #1;
        check({name, " single pulse"}, {31'b0, ready0}, 32'd0);
    endtask

    initial begin
        logic [31:0] gotData;
        logic        gotFault;
        logic        expFault;
        logic [3:0]  legalBe [7];
        int          n;

        legalBe = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        vecs[0]  = '{1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10010000, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h10010005, 32'h0000AA00, 4'b0010, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h10010006, 32'hBBBB0000, 4'b1100, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10010004, 32'h0,        4'b0000, 32'hBBBBAA44, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h10011000, 32'h0,        4'b0000, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h10010004, 32'h0,        4'b0000, 32'hBBBBAA44, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h10010002, 32'h0,        4'b0000, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h10010004, 32'h0,        4'b0000, 32'hBBBBAA44, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h10010004, 32'h12345678, 4'b0110, 32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h10010004, 32'h0,        4'b0000, 32'hBBBBAA44, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h10010000, 32'h0,        4'b1111, 32'h00000000, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h1000FFFC, 32'h0,        4'b0000, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'h10010FFC, 32'h55667788, 4'b1111, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h10010FFC, 32'h0,        4'b0000, 32'h55667788, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h10011000, 32'h99999999, 4'b1111, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 32'h10010001, 32'h000000EE, 4'b0001, 32'h00000000, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 32'h10010FFC, 32'h0,        4'b0000, 32'h55667788, 1'b0};

        resetN0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        resetN3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0; be3 = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            refMem[i] = $urandom();
            dut0.memArray.storage[i] = refMem[i];
        end
        refMem[1] = 32'h11223344;
        dut0.memArray.storage[1] = 32'h11223344;
        dut3.memArray.storage[2] = 32'hA5A50001;
        dut3.memArray.storage[3] = 32'h0BADF00D;
        dut3.memArray.storage[4] = 32'hCAFEF00D;
        refRead = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        check("reset ready", {31'b0, ready0}, 32'd0);
        check("reset fault", {31'b0, fault0}, 32'd0);
        check("reset readData", rdata0, 32'd0);
        @(negedge clock);
        resetN0 = 1'b1;
        resetN3 = 1'b1;

        // Directed vector table on the zero-wait instance.
        for (int i = 0; i < 18; i++) begin
            expFault = refApply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be);
            access0(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                    $sformatf("vec%0d", i), gotData, gotFault);
            check($sformatf("vec%0d fault", i), {31'b0, gotFault}, {31'b0, vecs[i].expFault});
            check($sformatf("vec%0d readData", i), gotData, vecs[i].expData);
        end

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            logic        rd, wr;
            logic [31:0] addr, data;
            logic [3:0]  be;
            int unsigned sel, idx, low;
            sel  = $urandom_range(0, 9);
            wr   = $urandom_range(0, 1) == 1;
            rd   = !wr || (sel == 9);
            be   = legalBe[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) be = 4'($urandom());
            low  = 0;
            if (wr) for (int k = 3; k >= 0; k--) if (be[k]) low = k;
            if (sel == 2) low = $urandom_range(0, 3);
            idx  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(1016, 1027);
            addr = (sel == 0) ? $urandom() : Base + 32'(idx) * 4 + 32'(low);
            data = $urandom();
            expFault = refApply(rd, wr, addr, data, be);
            access0(rd, wr, addr, data, be, $sformatf("rnd%0d", i), gotData, gotFault);
            check($sformatf("rnd%0d fault", i), {31'b0, gotFault}, {31'b0, expFault});
            check($sformatf("rnd%0d readData", i), gotData, refRead);
        end

        for (int i = 0; i < int'(Depth); i++) begin
            check($sformatf("mem word %0d", i), dut0.memArray.storage[i], refMem[i]);
        end

        // Three wait states: read at cycle 0, address changes mid-wait, a held request is
        // not re-accepted, and the next one is accepted one idle cycle later.
        @(negedge clock);
        rd3 = 1'b1; addr3 = 32'h10010008;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check($sformatf("ws3 ready edge%0d", i), {31'b0, ready3},
                  {31'b0, (i == 3) || (i == 8)});
            if (i == 0) addr3 = 32'h1001000C;
            if (i == 3) begin
                check("ws3 first readData", rdata3, 32'hA5A50001);
                check("ws3 first fault", {31'b0, fault3}, 32'd0);
            end
            if (i == 8) begin
                check("ws3 second readData", rdata3, 32'h0BADF00D);
                rd3 = 1'b0;
            end
        end

        // Reset while the write is waiting: nothing commits and no ready pulse.
        @(negedge clock);
        wr3 = 1'b1; addr3 = 32'h10010010; wdata3 = 32'h12345678; be3 = 4'b1111;
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN3 = 1'b0;
        #1;
        check("mid-wait reset readData", rdata3, 32'd0);
        check("mid-wait reset fault", {31'b0, fault3}, 32'd0);
        wr3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 2) resetN3 = 1'b1;
            @(posedge clock); #1;
            check($sformatf("mid-wait reset no ready %0d", i), {31'b0, ready3}, 32'd0);
        end
        check("mid-wait reset storage", dut3.memArray.storage[4], 32'hCAFEF00D);

        @(negedge clock);
        rd3 = 1'b1; addr3 = 32'h10010010;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!ready3 && n < 20);
        rd3 = 1'b0;
        check("post-reset read latency", 32'(n), 32'd4);
        check("post-reset readData", rdata3, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
